// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus controller: FSM states and response codes.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INT_ACC  = 2'd1,
    EXT_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OK          = 2'd0,
    ERR_ALIGN   = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } resp_t;

  function automatic logic is_err(resp_t r);
    return r != OK;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response and external-bus signals of the memory bus controller.
interface mem_bus_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [DATA_W/8-1:0]   cpu_be;
  logic                  cpu_ready;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_err;

  logic                  ext_req;
  logic                  ext_we;
  logic [ADDR_W-1:0]     ext_addr;
  logic [DATA_W-1:0]     ext_wdata;
  logic [DATA_W/8-1:0]   ext_be;
  logic [DATA_W-1:0]     ext_rdata;
  logic                  ext_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, ext_rdata, ext_ack,
    output cpu_ready, cpu_rdata, cpu_err, ext_req, ext_we, ext_addr, ext_wdata, ext_be
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, ext_rdata, ext_ack,
    input  cpu_ready, cpu_rdata, cpu_err, ext_req, ext_we, ext_addr, ext_wdata, ext_be
  );
endinterface

// File: rtl/mem_bus_sram.sv
// Single-port synchronous SRAM with byte enables; contents survive reset.
module mem_bus_sram #(
  parameter int DATA_W    = 32,
  parameter int INT_WORDS = 16384,
  localparam int BE_W     = DATA_W / 8,
  localparam int AW       = $clog2(INT_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [INT_WORDS];

  // Read data only updates on a read access, so it holds between accesses.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < BE_W; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU memory bus controller: decodes to internal SRAM or an external bus with
// ack timeout, and returns a one-cycle ready pulse with an error qualifier.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter int              INT_WORDS   = 16384,
  parameter logic [ADDR_W-1:0] INT_LIMIT = 'h0001_0000,
  parameter int              EXT_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  mem_bus_ctrl_if.slave   bus,
  output logic            busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(INT_WORDS);
  localparam logic [15:0] TO_LOAD = 16'(EXT_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_be;
  logic                r_ext_req;
  logic [15:0]         r_cnt;
  resp_t               r_resp;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_int_rd;

  logic                w_accept;
  logic                w_misalign;
  logic                w_is_int;
  logic [ADDR_W-1:0]   w_word;
  logic                w_range;
  logic                w_tc;
  logic                w_sram_en;
  logic [DATA_W-1:0]   w_sram_rdata;

  assign w_misalign = |bus.cpu_addr[OFF_W-1:0];
  assign w_is_int   = bus.cpu_addr < INT_LIMIT;
  assign w_word     = bus.cpu_addr >> OFF_W;
  assign w_range    = w_is_int && (w_word >= ADDR_W'(INT_WORDS));
  assign w_tc       = (r_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_sram_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cpu_req) begin
          w_accept = 1'b1;
          if (w_misalign || w_range) w_next = RESP;
          else if (w_is_int)         w_next = INT_ACC;
          else                       w_next = EXT_WAIT;
        end
      end
      INT_ACC: begin
        w_sram_en = 1'b1;
        w_next    = RESP;
      end
      EXT_WAIT: begin
        if (bus.ext_ack || w_tc) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_ext_req <= 1'b0;
      r_cnt     <= '0;
      r_resp    <= OK;
      r_rdata   <= '0;
      r_int_rd  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= bus.cpu_we;
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
            r_be    <= bus.cpu_be;
            r_cnt   <= TO_LOAD;
            if (w_misalign || w_range) begin
              r_resp   <= w_misalign ? ERR_ALIGN : ERR_RANGE;
              r_rdata  <= '0;
              r_int_rd <= 1'b0;
            end else if (!w_is_int) begin
              r_ext_req <= 1'b1;
            end
          end
        end
        INT_ACC: begin
          r_resp   <= OK;
          r_rdata  <= '0;
          r_int_rd <= !r_we;
        end
        EXT_WAIT: begin
          // A late ack wins over an expiring timeout in the same cycle.
          if (bus.ext_ack) begin
            r_ext_req <= 1'b0;
            r_resp    <= OK;
            r_rdata   <= r_we ? '0 : bus.ext_rdata;
            r_int_rd  <= 1'b0;
          end else if (w_tc) begin
            r_ext_req <= 1'b0;
            r_resp    <= ERR_TIMEOUT;
            r_rdata   <= '0;
            r_int_rd  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  mem_bus_sram #(
    .DATA_W    (DATA_W),
    .INT_WORDS (INT_WORDS)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (r_we),
    .i_addr  (r_addr[OFF_W +: IDX_W]),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .o_rdata (w_sram_rdata)
  );

  assign bus.cpu_ready = (r_state == RESP);
  assign bus.cpu_err   = is_err(r_resp);
  assign bus.cpu_rdata = r_int_rd ? w_sram_rdata : r_rdata;
  assign bus.ext_req   = r_ext_req;
  assign bus.ext_we    = r_we;
  assign bus.ext_addr  = r_addr;
  assign bus.ext_wdata = r_wdata;
  assign bus.ext_be    = r_be;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: internal, external, timeout, error and reset-abort traffic.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_bus_ctrl #(
    .DATA_W      (32),
    .ADDR_W      (32),
    .INT_WORDS   (1024),
    .INT_LIMIT   (32'h0001_0000),
    .EXT_TIMEOUT (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.cpu_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rdata", bus.cpu_rdata, e.rd);
        chk("err", bus.cpu_err, e.err);
      end
    end
  end

  // ack_at: wait cycle (1-based) on which ext_ack is raised; 0 never acks.
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic is_ext, input int ack_at, input logic [31:0] ack_data,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    int   n;
    exp_t e;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
    e.rd  = exp_rd;
    e.err = exp_err;
    q.push_back(e);
    @(negedge clk);
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = ~addr;
    bus.cpu_wdata = ~wdata;
    bus.cpu_be    = ~be;
    n = 1;
    while (!bus.cpu_ready && n < 40) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_ext_req"}, bus.ext_req, is_ext);
      if (is_ext) begin
        chk({tag, "_ext_addr"}, bus.ext_addr, addr);
        chk({tag, "_ext_we"}, bus.ext_we, we);
        chk({tag, "_ext_wdata"}, bus.ext_wdata, wdata);
        chk({tag, "_ext_be"}, bus.ext_be, be);
      end
      if (n == ack_at) begin
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = ack_data;
      end
      @(negedge clk);
      bus.ext_ack   = 1'b0;
      bus.ext_rdata = 32'hBAD0_BAD0;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_ext_req_at_ready"}, bus.ext_req, 0);
    @(negedge clk);
    chk({tag, "_ready_pulse"}, bus.cpu_ready, 0);
    chk({tag, "_rdata_hold"}, bus.cpu_rdata, exp_rd);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be    = '0;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_err", bus.cpu_err, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_ext_req", bus.ext_req, 0);
    chk("rst_ext_we", bus.ext_we, 0);
    chk("rst_ext_addr", bus.ext_addr, 0);
    chk("rst_ext_wdata", bus.ext_wdata, 0);
    chk("rst_ext_be", bus.ext_be, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    run_req("wr100", 1, 32'h100, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 32'h0, 0, 2);
    run_req("rd100", 0, 32'h100, 32'h0, 4'b1111, 0, 0, 0, 32'hDEAD_BEEF, 0, 2);
    run_req("wr100_be", 1, 32'h100, 32'h0000_AA00, 4'b0010, 0, 0, 0, 32'h0, 0, 2);
    run_req("rd100_be", 0, 32'h100, 32'h0, 4'b1111, 0, 0, 0, 32'hDEAD_AAEF, 0, 2);
    run_req("wr200", 1, 32'h200, 32'h1122_3344, 4'b1111, 0, 0, 0, 32'h0, 0, 2);
    run_req("wr200_be0", 1, 32'h200, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, 32'h0, 0, 2);
    run_req("rd200", 0, 32'h200, 32'h0, 4'b1111, 0, 0, 0, 32'h1122_3344, 0, 2);
    run_req("wr_last", 1, 32'hFFC, 32'hA5A5_5A5A, 4'b1111, 0, 0, 0, 32'h0, 0, 2);
    run_req("rd_last", 0, 32'hFFC, 32'h0, 4'b1111, 0, 0, 0, 32'hA5A5_5A5A, 0, 2);

    run_req("rd_misalign", 0, 32'h102, 32'h0, 4'b1111, 0, 0, 0, 32'h0, 1, 1);
    run_req("rd_range", 0, 32'h1000, 32'h0, 4'b1111, 0, 0, 0, 32'h0, 1, 1);
    run_req("rd_range_hi", 0, 32'hFFFC, 32'h0, 4'b1111, 0, 0, 0, 32'h0, 1, 1);
    run_req("rd_ext_misalign", 0, 32'h1_0002, 32'h0, 4'b1111, 0, 0, 0, 32'h0, 1, 1);

    run_req("ext_rd", 0, 32'h2_0000, 32'h0, 4'b1111, 1, 3, 32'h1234_5678, 32'h1234_5678, 0, 4);
    run_req("ext_rd_limit", 0, 32'h1_0000, 32'h0, 4'b1111, 1, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 2);
    run_req("ext_wr", 1, 32'h2_0004, 32'h0000_55AA, 4'b1001, 1, 2, 32'h7777_7777, 32'h0, 0, 3);
    run_req("ext_timeout", 0, 32'h4_0000, 32'h0, 4'b1111, 1, 0, 0, 32'h0, 1, 5);
    run_req("ext_ack_at_tc", 0, 32'h4_0000, 32'h0, 4'b1111, 1, 4, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 0, 5);

    // Stray ack while idle must not start or complete anything.
    @(negedge clk);
    bus.ext_ack   = 1'b1;
    bus.ext_rdata = 32'h5555_5555;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_busy", busy, 0);
      chk("idle_ack_ready", bus.cpu_ready, 0);
    end
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = 32'hBAD0_BAD0;

    // Reset in the middle of an external wait aborts it silently.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h3_0000;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    chk("abort_ext_req", bus.ext_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ext_req_cleared", bus.ext_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", bus.cpu_ready, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_ready", bus.cpu_ready, 0);

    run_req("rd100_post_rst", 0, 32'h100, 32'h0, 4'b1111, 0, 0, 0, 32'hDEAD_AAEF, 0, 2);

    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
